// File: rtl/cache_arb_pkg.sv
// Shared types for the cache arbiter: FSM state encoding and grant identifiers.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/cache_arbiter.sv
// Time-shares the physical-memory line port between the I-cache and D-cache,
// one transaction at a time, alternating grants when both sides contend.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       d_req_s;

  assign d_req_s = d_read | d_write;

  // Next-state arbitration plus the output mux driven from state and live requester inputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_addr    = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    i_rdata      = '0;
    d_resp       = 1'b0;
    d_rdata      = '0;
    case (state_q)
      IDLE: begin
        // A stray pmem_resp here is ignored; nothing is outstanding.
        if (i_read && d_req_s) begin
          if (last_grant_q == GRANT_D) begin
            state_d      = SERVE_I;
            last_grant_d = GRANT_I;
          end else begin
            state_d      = SERVE_D;
            last_grant_d = GRANT_D;
          end
        end else if (i_read) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
        end else if (d_req_s) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        pmem_addr = i_addr;
        if (pmem_resp) begin
          i_resp  = 1'b1;
          i_rdata = pmem_rdata;
          state_d = IDLE;
        end else begin
          state_d = SERVE_I;
        end
      end
      SERVE_D: begin
        // Strobes are forwarded as-is, including the illegal read+write combination.
        pmem_read  = d_read;
        pmem_write = d_write;
        pmem_addr  = d_addr;
        pmem_wdata = d_wdata;
        if (pmem_resp) begin
          d_resp  = 1'b1;
          d_rdata = pmem_rdata;
          state_d = IDLE;
        end else begin
          state_d = SERVE_D;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and grant-history registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: memory model, grant/response scoreboard, scenario tasks.
module tb_cache_arbiter;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int REP     = LINE_W / ADDR_W;
  localparam int MEM_LAT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_read, d_read, d_write;
  logic [ADDR_W-1:0] i_addr, d_addr, pmem_addr;
  logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata, pmem_wdata, pmem_rdata;
  logic              i_resp, d_resp, pmem_read, pmem_write, pmem_resp;

  logic              mem_resp_r, mem_mix, inj_resp;
  logic [LINE_W-1:0] mem_rdata_r, mem_pat, inj_data, wr_data_r;
  logic [ADDR_W-1:0] wr_addr_r;
  int                mem_cnt_r;
  logic              i_hold_r, d_hold_r;

  logic [ADDR_W-1:0] exp_grant_q[$];
  logic [LINE_W-1:0] exp_i_q[$];
  logic [LINE_W-1:0] exp_d_q[$];

  int errors = 0;
  int checks = 0;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  assign pmem_resp  = mem_resp_r | inj_resp;
  assign pmem_rdata = inj_resp ? inj_data : mem_rdata_r;

  // Memory model: answers a held strobe after MEM_LAT cycles with a one-cycle pulse.
  always @(posedge clk) begin
    if (reset) begin
      mem_resp_r  <= 1'b0;
      mem_rdata_r <= '0;
      mem_cnt_r   <= 0;
    end else if (mem_resp_r) begin
      mem_resp_r  <= 1'b0;
      mem_rdata_r <= '0;
      mem_cnt_r   <= 0;
    end else if (pmem_read || pmem_write) begin
      if (mem_cnt_r == MEM_LAT - 1) begin
        mem_resp_r  <= 1'b1;
        mem_cnt_r   <= 0;
        mem_rdata_r <= pmem_read ? (mem_mix ? (mem_pat ^ {REP{pmem_addr}}) : mem_pat) : '0;
        if (pmem_write) begin
          wr_addr_r <= pmem_addr;
          wr_data_r <= pmem_wdata;
        end
      end else begin
        mem_cnt_r <= mem_cnt_r + 1;
      end
    end else begin
      mem_cnt_r <= 0;
    end
  end

  // Requester protocol assertions: no read+write together, no request dropped before resp.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(d_read && d_write)) else $error("d_read and d_write asserted together");
      if (i_hold_r) assert (i_read) else $error("i_read dropped before i_resp");
      if (d_hold_r) assert (d_read || d_write) else $error("d request dropped before d_resp");
    end
    i_hold_r <= !reset && i_read && !i_resp;
    d_hold_r <= !reset && (d_read || d_write) && !d_resp;
  end

  // Scoreboard consumer: grant order on strobe rise, response data on resp, isolation otherwise.
  logic              strobe_prev;
  logic [ADDR_W-1:0] exp_a;
  logic [LINE_W-1:0] exp_l;
  always @(negedge clk) begin
    if (reset) begin
      strobe_prev = 1'b0;
    end else begin
      if ((pmem_read || pmem_write) && !strobe_prev) begin
        checks++;
        if (exp_grant_q.size() == 0) begin
          errors++;
          $display("FAIL grant_order: unexpected grant addr=%h, required no grant", pmem_addr);
        end else begin
          exp_a = exp_grant_q.pop_front();
          if (pmem_addr !== exp_a) begin
            errors++;
            $display("FAIL grant_order: addr=%h, required %h", pmem_addr, exp_a);
          end
        end
      end
      if (i_resp) begin
        checks++;
        if (exp_i_q.size() == 0) begin
          errors++;
          $display("FAIL i_resp_data: unexpected i_resp, required none");
        end else begin
          exp_l = exp_i_q.pop_front();
          if (i_rdata !== exp_l) begin
            errors++;
            $display("FAIL i_resp_data: got %h, required %h", i_rdata, exp_l);
          end
        end
      end
      if (d_resp) begin
        checks++;
        if (exp_d_q.size() == 0) begin
          errors++;
          $display("FAIL d_resp_data: unexpected d_resp, required none");
        end else begin
          exp_l = exp_d_q.pop_front();
          if (d_rdata !== exp_l) begin
            errors++;
            $display("FAIL d_resp_data: got %h, required %h", d_rdata, exp_l);
          end
        end
      end
      checks++;
      if ((!i_resp && i_rdata !== '0) || (!d_resp && d_rdata !== '0) || (i_resp && d_resp)) begin
        errors++;
        $display("FAIL isolation: i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h, required idle side zero",
                 i_resp, d_resp, i_rdata, d_rdata);
      end
      if (!pmem_read && !pmem_write) begin
        checks++;
        if (pmem_addr !== '0 || pmem_wdata !== '0) begin
          errors++;
          $display("FAIL idle_bus: addr=%h wdata=%h, required 0", pmem_addr, pmem_wdata);
        end
      end
      strobe_prev = pmem_read | pmem_write;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; inj_resp = 1'b0; inj_data = '0;
    mem_mix = 1'b0; mem_pat = '0;
    step(); step();
    @(negedge clk);
    checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 0000", {pmem_read, pmem_write, i_resp, d_resp});
    end
    checks++;
    if (i_rdata !== '0 || d_rdata !== '0 || pmem_wdata !== '0 || pmem_addr !== '0) begin
      errors++;
      $display("FAIL reset_buses: i_rdata=%h d_rdata=%h addr=%h, required 0", i_rdata, d_rdata, pmem_addr);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_i_read();
    int  resp_cyc = -1;
    logic d_seen = 1'b0;
    mem_mix = 1'b0;
    mem_pat = {REP{32'hA5A5_A5A5}};
    exp_grant_q.push_back(32'h0000_1000);
    exp_i_q.push_back({REP{32'hA5A5_A5A5}});
    i_addr = 32'h0000_1000; i_read = 1'b1;
    for (int c = 0; c < 30 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (pmem_read !== 1'b0) begin
          errors++; $display("FAIL i_early_strobe: pmem_read=%b, required 0", pmem_read);
        end
      end
      if (c == 1) begin
        checks++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_addr !== 32'h0000_1000) begin
          errors++;
          $display("FAIL i_strobe: rd=%b wr=%b addr=%h, required 1 0 00001000", pmem_read, pmem_write, pmem_addr);
        end
      end
      if (d_resp) d_seen = 1'b1;
      if (i_resp) resp_cyc = c;
    end
    checks++;
    if (resp_cyc != MEM_LAT + 1) begin
      errors++; $display("FAIL i_latency: resp cycle=%0d, required %0d", resp_cyc, MEM_LAT + 1);
    end
    step();
    i_read = 1'b0;
    @(negedge clk);
    checks++;
    if (i_resp !== 1'b0 || pmem_read !== 1'b0 || d_seen) begin
      errors++;
      $display("FAIL i_after: i_resp=%b pmem_read=%b d_seen=%b, required 0 0 0", i_resp, pmem_read, d_seen);
    end
    step();
  endtask

  task automatic test_d_write();
    int  resp_cyc = -1;
    logic i_seen = 1'b0;
    exp_grant_q.push_back(32'h0000_2000);
    exp_d_q.push_back('0);
    d_addr = 32'h0000_2000; d_wdata = {REP{32'h5A5A_5A5A}}; d_write = 1'b1;
    for (int c = 0; c < 30 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_addr !== 32'h0000_2000 ||
            pmem_wdata !== {REP{32'h5A5A_5A5A}}) begin
          errors++;
          $display("FAIL d_strobe: rd=%b wr=%b addr=%h wdata=%h, required 0 1 00002000 5a..5a",
                   pmem_read, pmem_write, pmem_addr, pmem_wdata);
        end
      end
      if (i_resp) i_seen = 1'b1;
      if (d_resp) resp_cyc = c;
    end
    checks++;
    if (resp_cyc != MEM_LAT + 1 || i_seen) begin
      errors++; $display("FAIL d_resp_timing: resp cycle=%0d i_seen=%b, required %0d 0", resp_cyc, i_seen, MEM_LAT + 1);
    end
    step();
    d_write = 1'b0; d_wdata = '0;
    checks++;
    if (wr_addr_r !== 32'h0000_2000 || wr_data_r !== {REP{32'h5A5A_5A5A}}) begin
      errors++; $display("FAIL d_mem_write: addr=%h data=%h, required 00002000 5a..5a", wr_addr_r, wr_data_r);
    end
    step();
  endtask

  task automatic test_contention();
    int   n_done = 0;
    logic gap = 1'b0, got_i, got_d;
    int   first_side = -1;
    reset = 1'b1; step(); step(); reset = 1'b0;
    mem_mix = 1'b1; mem_pat = {REP{32'h0F1E_2D3C}};
    exp_grant_q.push_back(32'h0000_4000);
    exp_grant_q.push_back(32'h0000_3000);
    exp_d_q.push_back({REP{32'h0F1E_2D3C}} ^ {REP{32'h0000_4000}});
    exp_i_q.push_back({REP{32'h0F1E_2D3C}} ^ {REP{32'h0000_3000}});
    i_addr = 32'h0000_3000; d_addr = 32'h0000_4000; i_read = 1'b1; d_read = 1'b1;
    for (int c = 0; c < 60 && n_done < 2; c++) begin
      @(negedge clk);
      if (gap) begin
        checks++;
        if (pmem_read || pmem_write) begin
          errors++; $display("FAIL contention_gap: strobes=%b%b, required 00", pmem_read, pmem_write);
        end
        gap = 1'b0;
      end
      got_i = i_resp; got_d = d_resp;
      if (first_side < 0 && got_d) first_side = 1;
      if (first_side < 0 && got_i) first_side = 0;
      step();
      if (got_d) begin d_read = 1'b0; n_done++; gap = 1'b1; end
      if (got_i) begin i_read = 1'b0; n_done++; gap = 1'b1; end
    end
    checks++;
    if (n_done != 2 || first_side != 1) begin
      errors++; $display("FAIL contention: done=%0d first=%0d, required 2 1(D)", n_done, first_side);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int   n_resp = 0, di = 0, ii = 0;
    logic got_i, got_d;
    for (int k = 0; k < 3; k++) begin
      exp_grant_q.push_back(32'h0000_5000 + 32'(k * 64));
      exp_grant_q.push_back(32'h0000_6000 + 32'(k * 64));
      exp_d_q.push_back(mem_pat ^ {REP{32'h0000_5000 + 32'(k * 64)}});
      exp_i_q.push_back(mem_pat ^ {REP{32'h0000_6000 + 32'(k * 64)}});
    end
    d_addr = 32'h0000_5000; i_addr = 32'h0000_6000; d_read = 1'b1; i_read = 1'b1;
    for (int c = 0; c < 200 && n_resp < 6; c++) begin
      @(negedge clk);
      got_i = i_resp; got_d = d_resp;
      if (got_i || got_d) begin
        checks++;
        if (got_d !== (n_resp % 2 == 0)) begin
          errors++; $display("FAIL b2b_order: resp #%0d went to d=%b, required d=%b", n_resp, got_d, n_resp % 2 == 0);
        end
        n_resp++;
      end
      step();
      if (got_d) begin
        di++;
        if (di < 3) d_addr = 32'h0000_5000 + 32'(di * 64);
        else d_read = 1'b0;
      end
      if (got_i) begin
        ii++;
        if (ii < 3) i_addr = 32'h0000_6000 + 32'(ii * 64);
        else i_read = 1'b0;
      end
    end
    checks++;
    if (n_resp != 6 || exp_grant_q.size() != 0) begin
      errors++; $display("FAIL b2b_count: resps=%0d pending grants=%0d, required 6 0", n_resp, exp_grant_q.size());
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic d_seen = 1'b0, i_got = 1'b0;
    mem_mix = 1'b0; mem_pat = {REP{32'hC3C3_C3C3}};
    exp_grant_q.push_back(32'h0000_7000);
    d_addr = 32'h0000_7000; d_wdata = {REP{32'h3C3C_3C3C}}; d_write = 1'b1;
    step(); step(); step();
    reset = 1'b1;
    step();
    d_write = 1'b0; d_wdata = '0;
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || d_resp !== 1'b0) begin
      errors++; $display("FAIL reset_abort: rd=%b wr=%b d_resp=%b, required 0 0 0", pmem_read, pmem_write, d_resp);
    end
    step();
    reset = 1'b0;
    exp_grant_q.push_back(32'h0000_8000);
    exp_i_q.push_back({REP{32'hC3C3_C3C3}});
    i_addr = 32'h0000_8000; i_read = 1'b1;
    for (int c = 0; c < 30 && !i_got; c++) begin
      @(negedge clk);
      if (d_resp) d_seen = 1'b1;
      if (i_resp) i_got = 1'b1;
    end
    checks++;
    if (!i_got || d_seen) begin
      errors++; $display("FAIL reset_then_i: i_got=%b d_seen=%b, required 1 0", i_got, d_seen);
    end
    step();
    i_read = 1'b0;
    step();
  endtask

  task automatic test_idle_resp();
    inj_data = {REP{32'hDEAD_BEEF}};
    inj_resp = 1'b1;
    @(negedge clk);
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== '0 || d_rdata !== '0) begin
      errors++;
      $display("FAIL idle_resp: i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h, required all 0", i_resp, d_resp, i_rdata, d_rdata);
    end
    step();
    inj_resp = 1'b0;
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
      errors++; $display("FAIL idle_after: rd=%b wr=%b i_resp=%b d_resp=%b, required 0 0 0 0",
                         pmem_read, pmem_write, i_resp, d_resp);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_idle_resp();
    checks++;
    if (exp_grant_q.size() != 0 || exp_i_q.size() != 0 || exp_d_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: grants=%0d i=%0d d=%0d left, required 0 0 0",
               exp_grant_q.size(), exp_i_q.size(), exp_d_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache (read-only) and the data cache (read/write).
- Sits below both L1 caches. It sequences one line transaction at a time and returns the response only to the requester it granted.
- Alternates grants under contention, so neither the IF stage nor the MEM stage can be starved while the pipeline stalls on misses.

Parameters:
- ADDR_W, 32, line address width (byte address, line-aligned by the caches)
- LINE_W, 256, cache line width in bits

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- i_read  input  1  I-cache line read request; held until i_resp
- i_addr  input  ADDR_W  I-cache line address
- i_rdata  output  LINE_W  line returned to I-cache
- i_resp  output  1  one-cycle completion pulse to I-cache
- d_read  input  1  D-cache line read request; held until d_resp
- d_write  input  1  D-cache line writeback request; held until d_resp
- d_addr  input  ADDR_W  D-cache line address
- d_wdata  input  LINE_W  writeback line
- d_rdata  output  LINE_W  line returned to D-cache
- d_resp  output  1  one-cycle completion pulse to D-cache
- pmem_read  output  1  memory read strobe, held until pmem_resp
- pmem_write  output  1  memory write strobe, held until pmem_resp
- pmem_addr  output  ADDR_W  memory address
- pmem_wdata  output  LINE_W  memory write data
- pmem_rdata  input  LINE_W  memory read data, valid with pmem_resp
- pmem_resp  input  1  memory completion pulse

Behaviour:
- Clock is clk. Reset is reset, synchronous and active-high. Everything is sampled on the posedge of clk.
- State register: IDLE, SERVE_I, SERVE_D. There is also a 1-bit last_grant register (0 = I, 1 = D).
- Reset:
  - State becomes IDLE and last_grant becomes 0.
  - All outputs are 0 in IDLE: pmem_*, i_resp, d_resp, and both rdata buses.
  - Reset mid-transaction abandons the transaction. No resp pulse is issued, and pmem strobes drop in the cycle after reset is sampled. The memory model shares the same reset.
- Arbitration in IDLE, on each posedge:
  - Only I pending (i_read) goes to SERVE_I.
  - Only D pending (d_read|d_write) goes to SERVE_D.
  - Both pending: if last_grant=D, go to SERVE_I; otherwise go to SERVE_D.
  - last_grant updates to the chosen side.
- SERVE_I:
  - pmem_read=1, pmem_write=0, pmem_addr=i_addr.
  - On pmem_resp: i_resp=1 and i_rdata=pmem_rdata in the same cycle (combinational). Next state is IDLE.
- SERVE_D:
  - pmem_read=d_read, pmem_write=d_write, pmem_addr=d_addr, pmem_wdata=d_wdata.
  - On pmem_resp: d_resp=1 and d_rdata=pmem_rdata in the same cycle. Next state is IDLE.
- Outputs are decoded from state plus live requester inputs.
  - Requesters hold addr/data/strobes stable from assertion through resp.
  - Dropping a request before resp is illegal; the bench checks it with an assertion.
- Non-granted side: resp=0 and rdata=0 at all times.
- pmem_wdata is 0 outside SERVE_D.
- Latency:
  - A request seen in IDLE at edge t drives pmem strobes from t+1.
  - The requester's resp coincides with pmem_resp.
  - There is one mandatory IDLE cycle between back-to-back transactions, so strobes drop for at least one cycle.
- Illegal input: d_read and d_write asserted together; the bench flags it with an assertion. RTL forwards both strobes unchanged.
- pmem_resp in IDLE is ignored. No resp pulse is issued.

Decomposition:
- Package cache_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, SERVE_I, SERVE_D}
  - localparams GRANT_I = 1'b0, GRANT_D = 1'b1
- Single module with no sub-module. FSM and output mux live in one always_ff and one always_comb.

Test Plan:
- i_read=1, i_addr=0x0000_1000; memory responds after 4 cycles with rdata=0xA5..A5:
  - pmem_read=1 and pmem_addr=0x1000 from cycle 1.
  - i_resp pulses once with i_rdata=0xA5..A5.
  - d_resp stays 0.
- d_write=1, d_addr=0x2000, d_wdata=0x5A..5A:
  - pmem_write=1 with matching addr/wdata.
  - pmem_read=0.
  - d_resp pulses on pmem_resp.
- Both requests rise together after reset (last_grant=0):
  - D is served first (pmem_addr=d_addr), then one IDLE cycle, then I.
  - Each resp goes only to its own requester.
- Both sides re-request immediately after every resp for 6 transactions:
  - Grant order is D,I,D,I,D,I.
  - No side waits more than one transaction.
- Reset asserted mid-SERVE_D (2 cycles before pmem_resp):
  - Next cycle all pmem strobes are 0, state is IDLE, and no d_resp.
  - After reset, a pending I request is granted first (last_grant=0 means D wins only when both are pending, so test I alone).
- pmem_resp pulsed while IDLE with no requests: i_resp, d_resp and the rdata buses all stay 0.
